// File: rtl/scpu_dmem_responder_if.sv
// Load/store bus between the SCPU data port (master) and its memory responder (slave).
interface scpu_dmem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        err;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, stall, err
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, stall, err
  );
endinterface

// File: rtl/scpu_dmem_responder.sv
// Word-addressed data memory for the SCPU that answers each load/store after
// WAIT_CYCLES wait states with a one-cycle ready strobe and an error flag.
module scpu_dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  scpu_dmem_responder_if.slave bus
);

  localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

  // The wait counter is only four bits wide, so larger settings cannot be honoured.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : gWaitCheck
    $error("scpu_dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAITING,
    RESP
  } stateT;

  stateT state;
  stateT nextState;

  logic [31:0]   mem [DEPTH];
  logic [3:0]    waitCnt;
  logic [AW-1:0] latIdx;
  logic [31:0]   latWdata;
  logic          latWrite;
  logic          latErr;
  logic [31:0]   rdataQ;
  logic          errQ;
  logic          readyInt;

  logic          reqValid;
  logic          reqErr;
  logic [AW-1:0] reqIdx;
  logic          respErr;
  logic          respWrite;
  logic [AW-1:0] respIdx;
  logic          enterResp;

  assign reqValid = bus.mem_read | bus.mem_write;
  assign reqErr   = (bus.addr[1:0] != 2'b00) | (bus.addr >= LIMIT) |
                    (bus.mem_read & bus.mem_write);
  assign reqIdx   = bus.addr[AW+1:2];

  // With zero wait states RESP is entered straight from IDLE, so the live request is used.
  assign respErr   = (state == IDLE) ? reqErr        : latErr;
  assign respWrite = (state == IDLE) ? bus.mem_write : latWrite;
  assign respIdx   = (state == IDLE) ? reqIdx        : latIdx;
  assign enterResp = (state != RESP) && (nextState == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (reqValid) begin
          nextState = (WAIT_CYCLES == 0) ? RESP : WAITING;
        end
      end
      WAITING: begin
        if (waitCnt <= 4'd1) begin
          nextState = RESP;
        end
      end
      RESP: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_comb begin
    readyInt  = (state == RESP);
    bus.ready = readyInt;
    bus.rdata = rdataQ;
    bus.err   = errQ;
    bus.stall = reqValid & ~readyInt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt <= 4'd0;
      rdataQ  <= 32'd0;
      errQ    <= 1'b0;
    end else begin
      if (state == IDLE && reqValid) begin
        waitCnt <= 4'(WAIT_CYCLES);
      end else if (state == WAITING) begin
        waitCnt <= waitCnt - 4'd1;
      end
      // Response data lives only for the RESP cycle and reads as zero otherwise.
      if (enterResp) begin
        errQ   <= respErr;
        rdataQ <= (respErr || respWrite) ? 32'd0 : mem[respIdx];
      end else begin
        errQ   <= 1'b0;
        rdataQ <= 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && reqValid) begin
      latIdx   <= reqIdx;
      latWdata <= bus.wdata;
      latWrite <= bus.mem_write;
      latErr   <= reqErr;
    end
  end

  // A store lands as RESP is left, and never on a reset edge or for an illegal request.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && latWrite && !latErr) begin
      mem[latIdx] <= latWdata;
    end
  end

endmodule

// File: tb/tb_scpu_dmem_responder.sv
// Self-checking bench for scpu_dmem_responder: directed vector table, reset
// corner sequences, zero-wait back-to-back reads, and randomized traffic vs. a memory model.
module tb_scpu_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WAITS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   assertCount = 0;
  int   failCount   = 0;

  scpu_dmem_responder_if bus ();
  scpu_dmem_responder_if bus0 ();

  scpu_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  scpu_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic        chkData;
    logic [31:0] expRdata;
  } vecT;

  logic [31:0] modelMem [DEPTH];

  function automatic logic [31:0] initWord(input int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  function automatic logic modelIllegal(input logic rd, input logic wr, input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * DEPTH) || (rd && wr);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: no ready within cycle budget, got 0, expected 1", name);
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               output logic gotErr, output logic [31:0] gotRdata, output int stallCycles,
                               output logic stallAtReady, output logic readyAfter,
                               output logic [31:0] rdataAfter, output bit timedOut);
    @(negedge clk);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    #1;
    stallCycles = 0;
    timedOut    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready === 1'b1) begin
        timedOut = 1'b0;
        break;
      end
      if (bus.stall === 1'b1) stallCycles++;
      @(negedge clk);
    end
    gotErr        = bus.err;
    gotRdata      = bus.rdata;
    stallAtReady  = bus.stall;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    readyAfter = bus.ready;
    rdataAfter = bus.rdata;
  endtask

  task automatic runAndCheck(input string name, input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic expErr, input logic chkData,
                             input logic [31:0] expRdata);
    logic        gotErr, stallAtReady, readyAfter;
    logic [31:0] gotRdata, rdataAfter;
    int          stallCycles;
    bit          timedOut;
    applyStimulus(rd, wr, a, wd, gotErr, gotRdata, stallCycles, stallAtReady, readyAfter, rdataAfter, timedOut);
    if (timedOut) begin
      reportTimeout(name);
      return;
    end
    checkOutput({name, " err"}, 32'(gotErr), 32'(expErr));
    if (chkData) checkOutput({name, " rdata"}, gotRdata, expRdata);
    checkOutput({name, " stall cycles"}, 32'(stallCycles), 32'(WAITS + 1));
    checkOutput({name, " stall with ready"}, 32'(stallAtReady), 32'd0);
    checkOutput({name, " ready after"}, 32'(readyAfter), 32'd0);
    checkOutput({name, " rdata after"}, rdataAfter, 32'd0);
  endtask

  task automatic modelApply(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    if (wr && !modelIllegal(rd, wr, a)) modelMem[a / 4] = wd;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecT         vecs [13];
    logic [31:0] a, wd, expR;
    logic        rd, wr, illegal;
    int          pulses, readyHighs;
    bit          sawReady;

    vecs[0]  = '{"wr 0x10",        1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{"rd 0x10",        1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{"rd 0x13 misal",  1'b1, 1'b0, 32'h13,  32'h0,        1'b1, 1'b1, 32'h0};
    vecs[3]  = '{"rd 0x10 again",  1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[4]  = '{"wr 0x400 oob",   1'b0, 1'b1, 32'h400, 32'h1234,     1'b1, 1'b0, 32'h0};
    vecs[5]  = '{"rd 0x000",       1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'hA5A50000};
    vecs[6]  = '{"rd+wr 0x10",     1'b1, 1'b1, 32'h10,  32'h11111111, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{"rd 0x10 intact", 1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[8]  = '{"rd 0x3FC last",  1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 1'b1, 32'hA5A500FF};
    vecs[9]  = '{"wr 0x3FC last",  1'b0, 1'b1, 32'h3FC, 32'h55AA55AA, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{"rd 0x3FC new",   1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 1'b1, 32'h55AA55AA};
    vecs[11] = '{"wr 0xFFFFFFFC",  1'b0, 1'b1, 32'hFFFFFFFC, 32'h9,   1'b1, 1'b0, 32'h0};
    vecs[12] = '{"wr 0x2 misal",   1'b0, 1'b1, 32'h2,   32'h77,       1'b1, 1'b0, 32'h0};

    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.addr       = 32'h0;
    bus.wdata      = 32'h0;
    bus0.mem_read  = 1'b0;
    bus0.mem_write = 1'b0;
    bus0.addr      = 32'h0;
    bus0.wdata     = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset ready", 32'(bus.ready), 32'd0);
    checkOutput("reset err", 32'(bus.err), 32'd0);
    checkOutput("reset rdata", bus.rdata, 32'd0);
    checkOutput("reset stall", 32'(bus.stall), 32'd0);
    checkOutput("reset ready w0", 32'(bus0.ready), 32'd0);
    rst = 1'b0;

    // Give every word a known value so later reads have a defined expectation.
    for (int i = 0; i < DEPTH; i++) begin
      runAndCheck("init wr", 1'b0, 1'b1, 32'(i * 4), initWord(i), 1'b0, 1'b0, 32'h0);
      modelMem[i] = initWord(i);
    end

    foreach (vecs[i]) begin
      runAndCheck(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                  vecs[i].expErr, vecs[i].chkData, vecs[i].expRdata);
      modelApply(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
    end

    // Reset while waiting: the write is abandoned and no ready appears.
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.addr      = 32'h20;
    bus.wdata     = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("wait stall", 32'(bus.stall), 32'd1);
    rst           = 1'b1;
    bus.mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    readyHighs = 0;
    for (int k = 0; k < WAITS + 3; k++) begin
      if (bus.ready === 1'b1) readyHighs++;
      @(negedge clk);
    end
    checkOutput("rst in wait ready", 32'(readyHighs), 32'd0);
    runAndCheck("rd 0x20 after rst", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, initWord(8));

    // Reset during RESP: the store must not commit on that edge.
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.addr      = 32'h24;
    bus.wdata     = 32'h77777777;
    sawReady = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        sawReady = 1'b1;
        break;
      end
    end
    if (!sawReady) reportTimeout("rst in resp");
    rst           = 1'b1;
    bus.mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst in resp ready", 32'(bus.ready), 32'd0);
    runAndCheck("rd 0x24 after rst", 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, initWord(9));

    // Zero-wait instance: write, then hold a read so ready toggles every other cycle.
    @(negedge clk);
    bus0.mem_write = 1'b1;
    bus0.addr      = 32'h10;
    bus0.wdata     = 32'hDEADBEEF;
    #1;
    checkOutput("w0 stall", 32'(bus0.stall), 32'd1);
    @(negedge clk);
    checkOutput("w0 wr ready", 32'(bus0.ready), 32'd1);
    checkOutput("w0 wr err", 32'(bus0.err), 32'd0);
    bus0.mem_write = 1'b0;
    @(negedge clk);
    bus0.mem_read = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkOutput("w0 hold ready", 32'(bus0.ready), 32'(k % 2));
      if (bus0.ready === 1'b1) begin
        pulses++;
        checkOutput("w0 hold rdata", bus0.rdata, 32'hDEADBEEF);
      end
    end
    checkOutput("w0 pulse count", 32'(pulses), 32'd5);
    bus0.mem_read = 1'b0;

    for (int n = 0; n < 80; n++) begin
      int r, kind;
      r    = $urandom_range(0, 9);
      kind = $urandom_range(0, 4);
      if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (r == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (r == 8) a = 32'(4 * DEPTH + $urandom_range(0, 1000) * 4);
      else             a = $urandom;
      rd      = (kind <= 1) || (kind == 4);
      wr      = (kind >= 2);
      wd      = $urandom;
      illegal = modelIllegal(rd, wr, a);
      expR    = (illegal || wr) ? 32'h0 : modelMem[a / 4];
      runAndCheck("random", rd, wr, a, wd, illegal, rd || illegal, expR);
      modelApply(rd, wr, a, wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
